sys_tile_sequencer: RTL and testbench

- Parametrised phase sequencer for the N x N weight-stationary systolic array.
- Drives clear, A-load, W-load, drain and output-deload strobes for a programmable number of K-accumulation steps per output tile and output tiles per job.
- Adds a start/busy/done handshake and a global stall.
- Sits between the job front-end and the array/deload datapath; replaces the fixed-length free-running controller.

---
 rtl/sys_ctrl_pkg.sv | 7 +
 rtl/sys_phase_counter.sv | 18 +
 rtl/sys_tile_sequencer.sv | 103 ++++++++++
 tb/tb_sys_tile_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared state encoding and sizing helpers for the systolic tile sequencer.
package sys_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_A, LOAD_W, DRAIN, OUT, DONE} state_t;
  function automatic int phase_w(input int n);
    return (n > 1) ? $clog2(2 * n) : 1;
  endfunction
endpackage

// File: rtl/sys_phase_counter.sv
// sys_phase_counter: per-state phase counter that wraps on its terminal count and flags the last cycle.
module sys_phase_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] len_m1,
  output logic         last
);
  logic [W-1:0] cnt;
  assign last = cnt == len_m1;
  always_ff @(posedge clk) begin
    if (reset || load) cnt <= '0;
    else if (en) cnt <= last ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/sys_tile_sequencer.sv
// sys_tile_sequencer: phase sequencer driving clear/load/drain/deload strobes for K steps x M tiles per job.
module sys_tile_sequencer
  import sys_ctrl_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic [CNT_W-1:0] k_tiles,
  input  logic [CNT_W-1:0] m_tiles,
  output logic             busy,
  output logic             done,
  output logic             reset_sys,
  output logic             compute,
  output logic             load_a,
  output logic             load_w,
  output logic             deload,
  output logic             deload_out,
  output logic [CNT_W-1:0] k_idx,
  output logic [CNT_W-1:0] m_idx
);
  localparam int LEN_LOAD  = N;
  localparam int LEN_DRAIN = 2 * N;
  localparam int PW        = phase_w(N);
  state_t           state, nxt;
  logic [CNT_W-1:0] k_last, m_last;
  logic [PW-1:0]    len_m1;
  logic             last;
  logic             clr_q, cmp_q, la_q, lw_q, dr_q, out_q, done_q;
  always_comb
    len_m1 = (state == DRAIN) ? PW'(LEN_DRAIN - 1) :
             (state == LOAD_A || state == LOAD_W || state == OUT) ? PW'(LEN_LOAD - 1) : '0;
  sys_phase_counter #(.W(PW)) u_phase (
    .clk    (clk),
    .reset  (reset),
    .load   (state == IDLE),
    .en     (!stall),
    .len_m1 (len_m1),
    .last   (last)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? CLEAR : IDLE;
      CLEAR:   nxt = LOAD_A;
      LOAD_A:  nxt = last ? LOAD_W : LOAD_A;
      LOAD_W:  nxt = last ? DRAIN : LOAD_W;
      DRAIN:   nxt = !last ? DRAIN : (k_idx < k_last) ? LOAD_A : OUT;
      OUT:     nxt = !last ? OUT : (m_idx < m_last) ? CLEAR : DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Strobes are registered from the next state so each is a clean Moore flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      k_last <= '0;
      m_last <= '0;
      k_idx  <= '0;
      m_idx  <= '0;
      busy   <= 1'b0;
      clr_q  <= 1'b0;
      cmp_q  <= 1'b0;
      la_q   <= 1'b0;
      lw_q   <= 1'b0;
      dr_q   <= 1'b0;
      out_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (!stall) begin
      state  <= nxt;
      busy   <= nxt != IDLE;
      clr_q  <= nxt == CLEAR;
      cmp_q  <= nxt == LOAD_A && state != LOAD_A;
      la_q   <= nxt == LOAD_A;
      lw_q   <= nxt == LOAD_W;
      dr_q   <= nxt == DRAIN;
      out_q  <= nxt == OUT;
      done_q <= nxt == DONE;
      if (state == IDLE && start) begin
        k_last <= (k_tiles == '0) ? '0 : k_tiles - CNT_W'(1);
        m_last <= (m_tiles == '0) ? '0 : m_tiles - CNT_W'(1);
        k_idx  <= '0;
        m_idx  <= '0;
      end
      if (state == DRAIN && last && k_idx < k_last) k_idx <= k_idx + CNT_W'(1);
      if (state == OUT && last && m_idx < m_last) begin
        m_idx <= m_idx + CNT_W'(1);
        k_idx <= '0;
      end
    end
  end
  assign reset_sys  = clr_q & ~stall;
  assign compute    = cmp_q & ~stall;
  assign load_a     = la_q & ~stall;
  assign load_w     = lw_q & ~stall;
  assign deload     = dr_q & ~stall;
  assign deload_out = out_q & ~stall;
  assign done       = done_q & ~stall;
endmodule

// File: tb/tb_sys_tile_sequencer.sv
// tb_sys_tile_sequencer: randomized jobs checked cycle by cycle against a phase-list reference model.
module tb_sys_tile_sequencer;
  localparam int N  = 4;
  localparam int CW = 16;
  localparam logic [7:0] S_CLR = 8'b1000_0001, S_LA0 = 8'b0110_0001, S_LA = 8'b0010_0001,
                         S_LW  = 8'b0001_0001, S_DR  = 8'b0000_1001, S_OT = 8'b0000_0101,
                         S_DN  = 8'b0000_0011;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0;
  logic [CW-1:0] k_tiles = '0, m_tiles = '0;
  logic busy, done, reset_sys, compute, load_a, load_w, deload, deload_out;
  logic [CW-1:0] k_idx, m_idx;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  sys_tile_sequencer #(.N(N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .k_tiles(k_tiles), .m_tiles(m_tiles),
    .busy(busy), .done(done), .reset_sys(reset_sys), .compute(compute), .load_a(load_a),
    .load_w(load_w), .deload(deload), .deload_out(deload_out), .k_idx(k_idx), .m_idx(m_idx)
  );
  function automatic logic [7:0] strb();
    return {reset_sys, compute, load_a, load_w, deload, deload_out, done, busy};
  endfunction
  function automatic logic [39:0] obs();
    return {strb(), k_idx, m_idx};
  endfunction
  function automatic logic [39:0] ent(input logic [7:0] s, input int k, input int m);
    return {s, CW'(k), CW'(m)};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Expected trace is the job's phase list written out from K, M and N; stalled cycles are extra.
  task automatic run_job(input int k, input int m, input int pct, input int st_at, input int st_len,
                         input bit noise, input bit hold);
    int ke, me, i, nst, dir, bc;
    logic [39:0] q[$];
    logic [39:0] e;
    ke = (k == 0) ? 1 : k;
    me = (m == 0) ? 1 : m;
    for (int mi = 0; mi < me; mi++) begin
      q.push_back(ent(S_CLR, 0, mi));
      for (int ki = 0; ki < ke; ki++) begin
        for (int p = 0; p < N; p++) q.push_back(ent(p == 0 ? S_LA0 : S_LA, ki, mi));
        for (int p = 0; p < N; p++) q.push_back(ent(S_LW, ki, mi));
        for (int p = 0; p < 2 * N; p++) q.push_back(ent(S_DR, ki, mi));
      end
      for (int p = 0; p < N; p++) q.push_back(ent(S_OT, ke - 1, mi));
    end
    q.push_back(ent(S_DN, ke - 1, me - 1));
    i = 0; nst = 0; dir = 0; bc = 0;
    k_tiles = CW'(k); m_tiles = CW'(m); start = 1'b1; stall = 1'b0;
    while (i < q.size()) begin
      @(negedge clk);
      start = hold ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
      if (noise) begin
        k_tiles = CW'($urandom_range(0, 7));
        m_tiles = CW'($urandom_range(0, 7));
      end
      stall = (i == st_at && dir < st_len) || (int'($urandom_range(0, 99)) < pct);
      #1;
      if (busy) bc++;
      if (stall) begin
        nst++;
        if (i == st_at) dir++;
        e = q[i];
        chk($sformatf("stall k%0d m%0d cyc%0d", k, m, i), obs(), {8'h01, e[31:0]});
      end else begin
        chk($sformatf("job k%0d m%0d cyc%0d", k, m, i), obs(), q[i]);
        i++;
      end
    end
    @(negedge clk);
    stall = 1'b0;
    start = hold;
    #1;
    chk($sformatf("idle k%0d m%0d", k, m), strb(), 8'h00);
    chk($sformatf("busy_cycles k%0d m%0d", k, m), bc, me * (1 + ke * 4 * N + N) + 1 + nst);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_held", obs(), 40'h0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_state", obs(), 40'h0);
    run_job(1, 1, 0, -1, 0, 1'b0, 1'b0);
    run_job(3, 2, 0, -1, 0, 1'b0, 1'b0);
    run_job(1, 1, 0, 6, 3, 1'b0, 1'b0);
    k_tiles = CW'(2); m_tiles = CW'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("pre_reset_drain", strb(), S_DR);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset", obs(), 40'h0);
    run_job(1, 1, 0, -1, 0, 1'b0, 1'b0);
    run_job(2, 2, 0, -1, 0, 1'b1, 1'b0);
    run_job(0, 0, 0, -1, 0, 1'b0, 1'b0);
    run_job(1, 1, 0, -1, 0, 1'b0, 1'b1);
    run_job(1, 1, 0, -1, 0, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++)
      run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 20, -1, 0, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
